// File: rtl/led_fill_pkg.sv
// Shared types and widths for the LED fill-bar scheduler.
// Optional drain behaviour is enabled by defining LED_FILL_DECAY_EN.
package led_fill_pkg;
    typedef enum logic [1:0] {IDLE, RUN, GRANT} state_e;
    localparam int STAGE_W = 4;
    localparam int TMR_W   = 24;
endpackage

// File: rtl/led_fill_timer.sv
// Period counter: advances while enabled, wraps at PERIOD-1 and flags the terminal count.
module led_fill_timer
    import led_fill_pkg::*;
#(
    parameter int PERIOD = 1300
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);
    logic [TMR_W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == TMR_W'(PERIOD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i)
            cnt_d = tc_o ? '0 : cnt_q + TMR_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: rtl/led_fill_scheduler.sv
// Round-robin scheduler sharing one period timer between the left and right LED fill bars.
// Define LED_FILL_DECAY_EN to let a released requester drain its bar one step per grant.
module led_fill_scheduler
    import led_fill_pkg::*;
#(
    parameter int PERIOD  = 1300,
    parameter int L_WIDTH = 5,
    parameter int R_WIDTH = 7
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               req_l,
    input  logic               req_r,
    input  logic               clear,
    output logic [L_WIDTH-1:0] ledL,
    output logic [R_WIDTH-1:0] ledR,
    output logic               grant_l,
    output logic               grant_r,
    output logic               done_l,
    output logic               done_r,
    output logic               completed
);
    localparam logic [STAGE_W-1:0] LMAX = STAGE_W'(L_WIDTH);
    localparam logic [STAGE_W-1:0] RMAX = STAGE_W'(R_WIDTH);

    state_e             state_q, state_d;
    logic [STAGE_W-1:0] stage_l_q, stage_l_d, stage_r_q, stage_r_d;
    logic               rr_q, rr_d;
    logic               gsel_q, gsel_d;   // side chosen for the pending GRANT (1 = right)
    logic               completed_q, completed_d;
    logic               elig_l, elig_r, tmr_en, tmr_tc;
`ifdef LED_FILL_DECAY_EN
    logic               gup_q, gup_d;     // pending GRANT fills (1) or drains (0)
`endif

    function automatic logic elig(input logic req, input logic [STAGE_W-1:0] st,
                                  input logic [STAGE_W-1:0] mx);
`ifdef LED_FILL_DECAY_EN
        return req ? (st != mx) : (st != '0);
`else
        return req && (st != mx);
`endif
    endfunction

    function automatic logic [STAGE_W-1:0] step_up(input logic [STAGE_W-1:0] st,
                                                   input logic [STAGE_W-1:0] mx);
        return (st == mx) ? st : st + STAGE_W'(1);
    endfunction

`ifdef LED_FILL_DECAY_EN
    function automatic logic [STAGE_W-1:0] step_dn(input logic [STAGE_W-1:0] st);
        return (st == '0) ? st : st - STAGE_W'(1);
    endfunction
`endif

    assign elig_l = elig(req_l, stage_l_q, LMAX);
    assign elig_r = elig(req_r, stage_r_q, RMAX);

    led_fill_timer #(.PERIOD(PERIOD)) u_timer (
        .clk_i   (clock),
        .rst_n_i (resetn),
        .clr_i   (clear),
        .en_i    (tmr_en),
        .tc_o    (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        stage_l_d   = stage_l_q;
        stage_r_d   = stage_r_q;
        rr_d        = rr_q;
        gsel_d      = gsel_q;
        completed_d = done_l & done_r;
        tmr_en      = 1'b0;
`ifdef LED_FILL_DECAY_EN
        gup_d       = gup_q;
`endif
        case (state_q)
            IDLE: if (elig_l || elig_r) state_d = RUN;
            RUN: begin
                if (!(elig_l || elig_r)) begin
                    state_d = IDLE;
                end else begin
                    tmr_en = 1'b1;
                    if (tmr_tc) begin
                        state_d = GRANT;
                        if (elig_l && elig_r) begin
                            gsel_d = rr_q;
                            rr_d   = ~rr_q;
                        end else begin
                            gsel_d = elig_r;
                            rr_d   = ~elig_r;
                        end
`ifdef LED_FILL_DECAY_EN
                        gup_d = gsel_d ? req_r : req_l;
`endif
                    end
                end
            end
            GRANT: begin
`ifdef LED_FILL_DECAY_EN
                if (!gsel_q) stage_l_d = gup_q ? step_up(stage_l_q, LMAX) : step_dn(stage_l_q);
                else         stage_r_d = gup_q ? step_up(stage_r_q, RMAX) : step_dn(stage_r_q);
`else
                if (!gsel_q) stage_l_d = step_up(stage_l_q, LMAX);
                else         stage_r_d = step_up(stage_r_q, RMAX);
`endif
                state_d = (elig(req_l, stage_l_d, LMAX) || elig(req_r, stage_r_d, RMAX))
                          ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // clear overrides any grant in flight, including the stage step
        if (clear) begin
            state_d     = IDLE;
            stage_l_d   = '0;
            stage_r_d   = '0;
            rr_d        = 1'b0;
            gsel_d      = 1'b0;
            completed_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            stage_l_q   <= '0;
            stage_r_q   <= '0;
            rr_q        <= 1'b0;
            gsel_q      <= 1'b0;
            completed_q <= 1'b0;
`ifdef LED_FILL_DECAY_EN
            gup_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            stage_l_q   <= stage_l_d;
            stage_r_q   <= stage_r_d;
            rr_q        <= rr_d;
            gsel_q      <= gsel_d;
            completed_q <= completed_d;
`ifdef LED_FILL_DECAY_EN
            gup_q       <= gup_d;
`endif
        end
    end

    assign grant_l   = (state_q == GRANT) && !gsel_q;
    assign grant_r   = (state_q == GRANT) &&  gsel_q;
    assign done_l    = (stage_l_q == LMAX);
    assign done_r    = (stage_r_q == RMAX);
    assign completed = completed_q;

    always_comb begin
        ledL = '0;
        ledR = '0;
        for (int i = 0; i < L_WIDTH; i++) ledL[L_WIDTH-1-i] = (STAGE_W'(i) < stage_l_q);
        for (int i = 0; i < R_WIDTH; i++) ledR[i] = (STAGE_W'(i) < stage_r_q);
    end
endmodule

// File: tb/tb_led_fill_scheduler.sv
// Directed bench for led_fill_scheduler with PERIOD=4, L_WIDTH=5, R_WIDTH=7.
module tb_led_fill_scheduler;
    localparam int P  = 4;
    localparam int LW = 5;
    localparam int RW = 7;

    logic          clock = 1'b0;
    logic          resetn = 1'b0;
    logic          req_l = 1'b0, req_r = 1'b0, clear = 1'b0;
    logic [LW-1:0] ledL;
    logic [RW-1:0] ledR;
    logic          grant_l, grant_r, done_l, done_r, completed;
    int            nvec = 0, nerr = 0;
    int            cyc = -1;

    led_fill_scheduler #(.PERIOD(P), .L_WIDTH(LW), .R_WIDTH(RW)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .req_l     (req_l),
        .req_r     (req_r),
        .clear     (clear),
        .ledL      (ledL),
        .ledR      (ledR),
        .grant_l   (grant_l),
        .grant_r   (grant_r),
        .done_l    (done_l),
        .done_r    (done_r),
        .completed (completed)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // cycle N is the interval after the N-th rising edge following reset release
    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic start(input logic l, input logic r);
        resetn = 1'b0;
        clear  = 1'b0;
        req_l  = l;
        req_r  = r;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        cyc    = -1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        req_l  = 1'b1;
        req_r  = 1'b1;
        @(negedge clock);
        @(negedge clock);
        nvec++;
        if ({ledL, ledR} !== '0) begin
            nerr++;
            $display("FAIL reset_leds got=%b_%b exp=0", ledL, ledR);
        end
        nvec++;
        if ({grant_l, grant_r, done_l, done_r, completed} !== 5'b0) begin
            nerr++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {grant_l, grant_r, done_l, done_r, completed});
        end
    endtask

    task automatic test_both();
        logic eL, eR;
        start(1'b1, 1'b1);
        for (int c = 0; c <= 65; c++) begin
            tick();
            eL = (cyc inside {4, 14, 24, 34, 44});
            eR = (cyc inside {9, 19, 29, 39, 49, 54, 59});
            nvec++;
            if (grant_l !== eL) begin
                nerr++;
                $display("FAIL both_grant_l cyc=%0d got=%b exp=%b", cyc, grant_l, eL);
            end
            nvec++;
            if (grant_r !== eR) begin
                nerr++;
                $display("FAIL both_grant_r cyc=%0d got=%b exp=%b", cyc, grant_r, eR);
            end
            if (cyc == 44) begin
                nvec++;
                if (ledL !== 5'b11110 || done_l !== 1'b0) begin
                    nerr++;
                    $display("FAIL both_ledL_4 got=%b done=%b exp=11110 done=0", ledL, done_l);
                end
            end
            if (cyc == 45) begin
                nvec++;
                if (ledL !== 5'b11111 || done_l !== 1'b1) begin
                    nerr++;
                    $display("FAIL both_ledL_full got=%b done=%b exp=11111 done=1", ledL, done_l);
                end
            end
            if (cyc == 59) begin
                nvec++;
                if (ledR !== 7'h3F) begin
                    nerr++;
                    $display("FAIL both_ledR_6 got=%h exp=3f", ledR);
                end
            end
            if (cyc == 60) begin
                nvec++;
                if (ledR !== 7'h7F || done_r !== 1'b1 || completed !== 1'b0) begin
                    nerr++;
                    $display("FAIL both_ledR_full got=%h done_r=%b compl=%b exp=7f 1 0",
                             ledR, done_r, completed);
                end
            end
            if (cyc == 61) begin
                nvec++;
                if (completed !== 1'b1) begin
                    nerr++;
                    $display("FAIL both_completed got=%b exp=1", completed);
                end
            end
        end
    endtask

    task automatic test_right_only();
        logic eR;
        start(1'b0, 1'b1);
        for (int c = 0; c <= 45; c++) begin
            tick();
            eR = (cyc inside {4, 9, 14, 19, 24, 29, 34});
            nvec++;
            if (grant_r !== eR) begin
                nerr++;
                $display("FAIL ronly_grant_r cyc=%0d got=%b exp=%b", cyc, grant_r, eR);
            end
            nvec++;
            if ({grant_l, ledL, completed} !== '0) begin
                nerr++;
                $display("FAIL ronly_left cyc=%0d grant_l=%b ledL=%b compl=%b exp=0",
                         cyc, grant_l, ledL, completed);
            end
            if (cyc == 35) begin
                nvec++;
                if (ledR !== 7'h7F) begin
                    nerr++;
                    $display("FAIL ronly_ledR got=%h exp=7f", ledR);
                end
            end
        end
    endtask

`ifndef LED_FILL_DECAY_EN
    task automatic test_drop_left();
        logic          eL, eR;
        logic [LW-1:0] expL;
        start(1'b1, 1'b1);
        for (int c = 0; c <= 45; c++) begin
            tick();
            eL   = (cyc == 4);
            eR   = (cyc inside {9, 14, 19, 24, 29, 34, 39});
            expL = (cyc >= 5) ? 5'b10000 : 5'b00000;
            nvec++;
            if (grant_l !== eL || grant_r !== eR) begin
                nerr++;
                $display("FAIL drop_grants cyc=%0d got=%b%b exp=%b%b",
                         cyc, grant_l, grant_r, eL, eR);
            end
            nvec++;
            if (ledL !== expL) begin
                nerr++;
                $display("FAIL drop_ledL cyc=%0d got=%b exp=%b", cyc, ledL, expL);
            end
            if (cyc == 6) req_l = 1'b0;
        end
    endtask
`endif

    task automatic test_clear_grant();
        logic eL;
        start(1'b1, 1'b1);
        while (cyc < 4) tick();
        nvec++;
        if (grant_l !== 1'b1) begin
            nerr++;
            $display("FAIL clr_pre_grant got=%b exp=1", grant_l);
        end
        clear = 1'b1;
        tick();
        nvec++;
        if ({ledL, ledR, grant_l, grant_r, done_l, done_r, completed} !== '0) begin
            nerr++;
            $display("FAIL clr_outputs ledL=%b ledR=%b g=%b%b exp=all 0",
                     ledL, ledR, grant_l, grant_r);
        end
        clear = 1'b0;
        while (cyc < 12) begin
            tick();
            eL = (cyc == 10);
            nvec++;
            if (grant_l !== eL || grant_r !== 1'b0) begin
                nerr++;
                $display("FAIL clr_regrant cyc=%0d got=%b%b exp=%b0", cyc, grant_l, grant_r, eL);
            end
            nvec++;
            if (ledL !== ((cyc >= 11) ? 5'b10000 : 5'b00000)) begin
                nerr++;
                $display("FAIL clr_ledL cyc=%0d got=%b", cyc, ledL);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic eL;
        start(1'b1, 1'b1);
        while (cyc < 7) tick();
        nvec++;
        if (ledL !== 5'b10000) begin
            nerr++;
            $display("FAIL rmid_pre ledL got=%b exp=10000", ledL);
        end
        #1;
        resetn = 1'b0;
        #1;
        nvec++;
        if ({ledL, ledR, grant_l, grant_r, done_l, done_r, completed} !== '0) begin
            nerr++;
            $display("FAIL rmid_async ledL=%b ledR=%b exp=0", ledL, ledR);
        end
        @(negedge clock);
        resetn = 1'b1;
        cyc    = -1;
        for (int c = 0; c <= 5; c++) begin
            tick();
            eL = (cyc == 4);
            nvec++;
            if (grant_l !== eL || grant_r !== 1'b0) begin
                nerr++;
                $display("FAIL rmid_grant cyc=%0d got=%b%b exp=%b0", cyc, grant_l, grant_r, eL);
            end
        end
    endtask

`ifdef LED_FILL_DECAY_EN
    task automatic test_decay();
        logic          eL;
        logic [LW-1:0] expL;
        start(1'b1, 1'b0);
        for (int c = 0; c <= 34; c++) begin
            tick();
            eL = (cyc inside {4, 9, 14, 19, 24, 29});
            if      (cyc < 5)  expL = 5'b00000;
            else if (cyc < 10) expL = 5'b10000;
            else if (cyc < 15) expL = 5'b11000;
            else if (cyc < 20) expL = 5'b11100;
            else if (cyc < 25) expL = 5'b11000;
            else if (cyc < 30) expL = 5'b10000;
            else               expL = 5'b00000;
            nvec++;
            if (grant_l !== eL || grant_r !== 1'b0) begin
                nerr++;
                $display("FAIL decay_grant cyc=%0d got=%b%b exp=%b0", cyc, grant_l, grant_r, eL);
            end
            nvec++;
            if (ledL !== expL) begin
                nerr++;
                $display("FAIL decay_ledL cyc=%0d got=%b exp=%b", cyc, ledL, expL);
            end
            if (cyc == 15) req_l = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_both();
        test_right_only();
`ifndef LED_FILL_DECAY_EN
        test_drop_left();
`else
        test_decay();
`endif
        test_clear_grant();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
